// File: rtl/burst_ram_pkg.sv
// Shared types and constants for the burst_ram memory model.
package burst_ram_pkg;

  localparam int WORD_WIDTH = 64;
  localparam int MASK_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_IDLE        = 3'd1,
    ST_READ_WAIT   = 3'd2,
    ST_READ_BURST  = 3'd3,
    ST_WRITE_BURST = 3'd4
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/burst_ram.sv
// Behavioural burst memory with a calibration delay, fixed read latency and
// multi-beat read/write bursts that wrap at the top of the address space.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter string DATA_FILE                = "",
  parameter int    DEPTH_BITWIDTH           = 4,
  parameter int    BURST_COUNT              = 4,
  parameter int    CYCLES_BEFORE_DATA_VALID = 6,
  parameter int    CYCLES_BEFORE_INITIATED  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd,
  input  logic                      cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0]     wr_data,
  input  logic [MASK_WIDTH-1:0]     data_mask,
  output logic [WORD_WIDTH-1:0]     rd_data,
  output logic                      rd_data_valid,
  output logic                      init_calib,
  output logic                      busy
);

  localparam int DEPTH   = 1 << DEPTH_BITWIDTH;
  localparam int CNT_MAX = max_int(CYCLES_BEFORE_DATA_VALID, CYCLES_BEFORE_INITIATED);
  localparam int CNT_W   = $clog2(CNT_MAX + 2);
  localparam int BEAT_W  = $clog2(BURST_COUNT + 1);

  localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(CYCLES_BEFORE_DATA_VALID);
  // Zero calibration cycles still needs one edge to leave INIT.
  localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'((CYCLES_BEFORE_INITIATED == 0) ? 0 : CYCLES_BEFORE_INITIATED - 1);
  localparam logic [BEAT_W-1:0] RD_LAST   = BEAT_W'(BURST_COUNT);
  localparam logic [BEAT_W-1:0] WR_LAST   = BEAT_W'(BURST_COUNT - 1);

  logic [WORD_WIDTH-1:0]     r_mem [DEPTH];
  state_e                    r_state;
  logic [CNT_W-1:0]          r_lat_cnt;
  logic [BEAT_W-1:0]         r_beat_cnt;
  logic [DEPTH_BITWIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0]     r_rd_data;
  logic                      r_rd_data_valid;
  logic                      r_init_calib;
  logic                      r_busy;

  state_e                    w_state_nxt;
  logic [CNT_W-1:0]          w_lat_nxt;
  logic [BEAT_W-1:0]         w_beat_nxt;
  logic [DEPTH_BITWIDTH-1:0] w_addr_nxt;
  logic [WORD_WIDTH-1:0]     w_rd_data_nxt;
  logic                      w_valid_nxt;
  logic                      w_init_nxt;
  logic                      w_busy_nxt;
  logic                      w_we;
  logic [DEPTH_BITWIDTH-1:0] w_waddr;
  logic                      w_unused;

  // Byte enables are accepted for interface compatibility only.
  assign w_unused = ^data_mask;

  // Memory initial contents: zero-filled.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_cnt;
    w_beat_nxt    = r_beat_cnt;
    w_addr_nxt    = r_addr;
    w_rd_data_nxt = r_rd_data;
    w_valid_nxt   = 1'b0;
    w_init_nxt    = r_init_calib;
    w_busy_nxt    = r_busy;
    w_we          = 1'b0;
    w_waddr       = r_addr;
    case (r_state)
      ST_INIT: begin
        if (r_lat_cnt == INIT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_init_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_lat_nxt   = '0;
        end else begin
          w_lat_nxt = r_lat_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (cmd_en && cmd) begin
          w_we    = 1'b1;
          w_waddr = addr;
          if (BURST_COUNT > 1) begin
            w_state_nxt = ST_WRITE_BURST;
            w_busy_nxt  = 1'b1;
            w_addr_nxt  = addr + DEPTH_BITWIDTH'(1);
            w_beat_nxt  = BEAT_W'(1);
          end else begin
            w_addr_nxt = addr;
          end
        end else if (cmd_en) begin
          w_state_nxt = ST_READ_WAIT;
          w_busy_nxt  = 1'b1;
          w_addr_nxt  = addr;
          w_lat_nxt   = '0;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      ST_READ_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt   = ST_READ_BURST;
          w_rd_data_nxt = r_mem[r_addr];
          w_valid_nxt   = 1'b1;
          w_addr_nxt    = r_addr + DEPTH_BITWIDTH'(1);
          w_beat_nxt    = BEAT_W'(1);
        end else begin
          w_lat_nxt = r_lat_cnt + CNT_W'(1);
        end
      end
      ST_READ_BURST: begin
        if (r_beat_cnt == RD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_rd_data_nxt = r_mem[r_addr];
          w_valid_nxt   = 1'b1;
          w_addr_nxt    = r_addr + DEPTH_BITWIDTH'(1);
          w_beat_nxt    = r_beat_cnt + BEAT_W'(1);
        end
      end
      ST_WRITE_BURST: begin
        w_we       = 1'b1;
        w_addr_nxt = r_addr + DEPTH_BITWIDTH'(1);
        w_beat_nxt = r_beat_cnt + BEAT_W'(1);
        if (r_beat_cnt == WR_LAST) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_WRITE_BURST;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_busy_nxt  = 1'b1;
        w_init_nxt  = 1'b0;
        w_lat_nxt   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Counters, burst address and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt       <= '0;
      r_beat_cnt      <= '0;
      r_addr          <= '0;
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
      r_init_calib    <= 1'b0;
      r_busy          <= 1'b1;
    end else begin
      r_lat_cnt       <= w_lat_nxt;
      r_beat_cnt      <= w_beat_nxt;
      r_addr          <= w_addr_nxt;
      r_rd_data       <= w_rd_data_nxt;
      r_rd_data_valid <= w_valid_nxt;
      r_init_calib    <= w_init_nxt;
      r_busy          <= w_busy_nxt;
    end
  end

  // Memory write port; contents survive reset.
  always @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= wr_data;
  end

  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_data_valid;
  assign init_calib    = r_init_calib;
  assign busy          = r_busy;

endmodule

// File: tb/tb_burst_ram.sv
// Directed, scoreboard-based bench for burst_ram (DEPTH_BITWIDTH=9, B=4, D=6).
module tb_burst_ram;

  localparam int DW = 9;
  localparam int B  = 4;
  localparam int D  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd = 1'b0;
  logic          cmd_en = 1'b0;
  logic [DW-1:0] addr = '0;
  logic [63:0]   wr_data = 64'd0;
  logic [7:0]    data_mask = 8'h00;
  logic [63:0]   rd_data;
  logic          rd_data_valid;
  logic          init_calib;
  logic          busy;

  logic [63:0]   z_rd_data;
  logic          z_rd_data_valid;
  logic          z_init_calib;
  logic          z_busy;

  logic [63:0]   exp_mem [1 << DW];
  logic [63:0]   sb_q [$];
  int            n_assert = 0;
  int            n_fail   = 0;

  burst_ram #(
    .DATA_FILE(""), .DEPTH_BITWIDTH(DW), .BURST_COUNT(B),
    .CYCLES_BEFORE_DATA_VALID(D), .CYCLES_BEFORE_INITIATED(5)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy)
  );

  burst_ram #(
    .DATA_FILE(""), .DEPTH_BITWIDTH(DW), .BURST_COUNT(B),
    .CYCLES_BEFORE_DATA_VALID(D), .CYCLES_BEFORE_INITIATED(0)
  ) dut_zero (
    .clk(clk), .rst(rst), .cmd(1'b0), .cmd_en(1'b0), .addr('0),
    .wr_data(64'd0), .data_mask(8'h00), .rd_data(z_rd_data),
    .rd_data_valid(z_rd_data_valid), .init_calib(z_init_calib), .busy(z_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) check({tag, "_init_low_e4"}, {63'd0, init_calib}, 64'd0);
    end
    check({tag, "_init_e5"}, {63'd0, init_calib}, 64'd1);
    check({tag, "_busy_e5"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic write_burst(input logic [DW-1:0] a, input logic [7:0] mask,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    cmd = 1'b1; cmd_en = 1'b1; addr = a; data_mask = mask;
    for (int i = 0; i < B; i++) begin
      wr_data = d[i];
      exp_mem[DW'(a + DW'(i))] = d[i];
      tick();
      cmd_en = 1'b0;
      check("wr_valid_low", {63'd0, rd_data_valid}, 64'd0);
      check(i == B - 1 ? "wr_busy_end" : "wr_busy_mid", {63'd0, busy}, (i == B - 1) ? 64'd0 : 64'd1);
    end
  endtask

  task automatic read_burst(input logic [DW-1:0] a, input bit pulse, input int abort_beat);
    int beats = 0;
    logic [63:0] exp_word;
    for (int i = 0; i < B; i++) sb_q.push_back(exp_mem[DW'(a + DW'(i))]);
    cmd = 1'b0; cmd_en = 1'b1; addr = a;
    tick();
    cmd_en = 1'b0;
    check("rd_busy_start", {63'd0, busy}, 64'd1);
    for (int k = 1; k <= D + B + 1; k++) begin
      if (pulse) begin
        cmd = 1'b1; addr = a; wr_data = 64'hBADB_AD00_BADB_AD00;
        cmd_en = (k >= 2 && k <= 4);
      end
      tick();
      cmd_en = 1'b0;
      if (rd_data_valid) begin
        beats++;
        check("rd_beat_edge", 64'(k), 64'(D + beats));
        check("rd_busy_beat", {63'd0, busy}, 64'd1);
        if (sb_q.size() == 0) begin
          check("rd_sb_underflow", 64'(beats), 64'd0);
        end else begin
          exp_word = sb_q.pop_front();
          check("rd_data", rd_data, exp_word);
        end
        if (beats == abort_beat) begin
          rst = 1'b1;
          #1;
          check("abort_valid", {63'd0, rd_data_valid}, 64'd0);
          check("abort_busy", {63'd0, busy}, 64'd1);
          check("abort_init", {63'd0, init_calib}, 64'd0);
          sb_q.delete();
          tick();
          tick();
          rst = 1'b0;
          wait_init("reinit");
          return;
        end
      end
    end
    check("rd_beat_count", 64'(beats), 64'(B));
    check("rd_end_valid", {63'd0, rd_data_valid}, 64'd0);
    check("rd_end_busy", {63'd0, busy}, 64'd0);
    check("rd_sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << DW); i++) exp_mem[i] = 64'd0;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_init", {63'd0, init_calib}, 64'd0);
    check("rst_valid", {63'd0, rd_data_valid}, 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    rst = 1'b0;
    tick();
    check("zero_init_e1", {63'd0, z_init_calib}, 64'd1);
    check("zero_busy_e1", {63'd0, z_busy}, 64'd0);
    check("main_init_e1", {63'd0, init_calib}, 64'd0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 4) check("main_init_e4", {63'd0, init_calib}, 64'd0);
    end
    check("main_init_e5", {63'd0, init_calib}, 64'd1);
    check("main_busy_e5", {63'd0, busy}, 64'd0);

    write_burst(9'd8, 8'h00, 64'h11, 64'h22, 64'h33, 64'h44);
    read_burst(9'd8, 1'b0, 0);

    write_burst(9'd510, 8'h00, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D);
    read_burst(9'd510, 1'b0, 0);

    read_burst(9'd8, 1'b1, 0);
    read_burst(9'd8, 1'b0, 0);

    write_burst(9'd100, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    read_burst(9'd100, 1'b0, 0);

    read_burst(9'd8, 1'b0, 3);
    read_burst(9'd8, 1'b0, 0);
    read_burst(9'd510, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
